time_counter: RTL



---
 rtl/clock_pkg.sv | 26 ++
 rtl/bcd_digit.sv | 33 +++
 rtl/time_counter.sv | 82 ++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// clock_pkg: shared BCD time types, digit limits and the time-legality check.
//   bcd_t           4-bit BCD digit
//   time_t          packed {hr_t, hr_o, min_t, min_o}
//   is_legal_time() true for 00:00..23:59 with every digit a legal BCD value
package clock_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t hr_t;
        bcd_t hr_o;
        bcd_t min_t;
        bcd_t min_o;
    } time_t;

    localparam bcd_t MAX_MIN_T      = 4'd5;
    localparam bcd_t MAX_HR_T       = 4'd2;
    localparam bcd_t MAX_HR_O_AT_20 = 4'd3;

    function automatic logic is_legal_time(input time_t t);
        return (t.hr_t <= MAX_HR_T) && (t.hr_o <= 4'd9) &&
               ((t.hr_t != MAX_HR_T) || (t.hr_o <= MAX_HR_O_AT_20)) &&
               (t.min_t <= MAX_MIN_T) && (t.min_o <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: mod-(MAX+1) BCD digit counter with enable, synchronous load and carry.
//   clk, reset   clock, synchronous active-high reset to INIT
//   en           count up by one this edge
//   load, value  load value this edge (takes priority over en)
//   q            current digit
//   carry        combinational: en is set and q is at MAX, so this edge wraps to 0
module bcd_digit
    import clock_pkg::*;
#(
    parameter bcd_t MAX  = 4'd9,
    parameter bcd_t INIT = 4'd0
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic load,
    input  bcd_t value,
    output bcd_t q,
    output logic carry
);

    assign carry = en && (q == MAX);

    always_ff @(posedge clk) begin
        if (reset)
            q <= INIT;
        else if (load)
            q <= value;
        else if (en)
            q <= (q == MAX) ? 4'd0 : q + 4'd1;
    end

endmodule

// File: rtl/time_counter.sv
// time_counter: 24-hour BCD HH:MM wall clock advanced by the one_minute tick, loadable.
//   clk256         system clock
//   reset          synchronous active-high, restores INIT_TIME and clears pulses
//   one_minute     minute tick; only its rising edge advances time
//   load_new_time  request to load new_time this edge
//   new_time       BCD {hr_t, hr_o, min_t, min_o}
//   current_time   BCD time, same packing
//   time_changed   1-cycle pulse after an advance or accepted load
//   day_rollover   1-cycle pulse after 23:59 -> 00:00
//   load_err       1-cycle pulse after a rejected (illegal) load
module time_counter
    import clock_pkg::*;
#(
    parameter logic [15:0] INIT_TIME = 16'h0000
) (
    input  logic        clk256,
    input  logic        reset,
    input  logic        one_minute,
    input  logic        load_new_time,
    input  logic [15:0] new_time,
    output logic [15:0] current_time,
    output logic        time_changed,
    output logic        day_rollover,
    output logic        load_err
);

    localparam time_t INIT = INIT_TIME;

    time_t nt;
    bcd_t  min_o, min_t, hr_t, hr_o;
    logic  tick_d, tick_rise, legal, load_ok, adv, carry_mo, carry_mt, wrap_day;

    assign nt        = new_time;
    assign legal     = is_legal_time(nt);
    assign load_ok   = load_new_time && legal;
    assign tick_rise = one_minute && !tick_d;
    // an accepted load swallows a coincident tick
    assign adv       = tick_rise && !load_ok;
    assign wrap_day  = carry_mt && (hr_t == 4'd2) && (hr_o == 4'd3);

    bcd_digit #(.MAX(4'd9), .INIT(INIT.min_o)) u_min_o (
        .clk(clk256), .reset(reset), .en(adv), .load(load_ok),
        .value(nt.min_o), .q(min_o), .carry(carry_mo)
    );

    bcd_digit #(.MAX(MAX_MIN_T), .INIT(INIT.min_t)) u_min_t (
        .clk(clk256), .reset(reset), .en(carry_mo), .load(load_ok),
        .value(nt.min_t), .q(min_t), .carry(carry_mt)
    );

    // hours kept as one block because 23 wraps to 00 rather than at a digit limit
    always_ff @(posedge clk256) begin
        if (reset) begin
            hr_t <= INIT.hr_t;
            hr_o <= INIT.hr_o;
        end else if (load_ok) begin
            hr_t <= nt.hr_t;
            hr_o <= nt.hr_o;
        end else if (carry_mt) begin
            hr_t <= wrap_day ? 4'd0 : (hr_o == 4'd9) ? hr_t + 4'd1 : hr_t;
            hr_o <= (wrap_day || hr_o == 4'd9) ? 4'd0 : hr_o + 4'd1;
        end
    end

    // tick_d resets high so a tick held across reset release is not counted
    always_ff @(posedge clk256) begin
        if (reset) begin
            tick_d       <= 1'b1;
            time_changed <= 1'b0;
            day_rollover <= 1'b0;
            load_err     <= 1'b0;
        end else begin
            tick_d       <= one_minute;
            time_changed <= load_ok || adv;
            day_rollover <= wrap_day;
            load_err     <= load_new_time && !legal;
        end
    end

    assign current_time = {hr_t, hr_o, min_t, min_o};

endmodule
